// File: rtl/note_divider_ctrl.sv
// Keypad note controller: maps a held key plus octave shift to a tone divide
// factor, either jumping to each new note or gliding one LSB per GLIDE_DIV cycles.
module note_divider_ctrl #(
  parameter int DIV_W     = 16,
  parameter int OCT_MAX   = 4,
  parameter int OCT_RESET = 2,
  parameter int GLIDE_DIV = 1024,
  parameter int OCT_W     = $clog2(OCT_MAX + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             key_valid_i,
  input  logic [3:0]       key_value_i,
  input  logic             oct_up_i,
  input  logic             oct_dn_i,
  input  logic             glide_en_i,
  output logic [DIV_W-1:0] div_factor_o,
  output logic             note_active_o,
  output logic             gliding_o,
  output logic [OCT_W-1:0] oct_o
);

  localparam int               CNT_W     = (GLIDE_DIV > 1) ? $clog2(GLIDE_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(GLIDE_DIV - 1);
  localparam logic [OCT_W-1:0] OCT_TOP   = OCT_W'(OCT_MAX);
  localparam logic [OCT_W-1:0] OCT_HOME  = OCT_W'(OCT_RESET);
  localparam logic [DIV_W-1:0] DIV_RESET = DIV_W'(128);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_GLIDE = 2'd2
  } state_e;

  // Base divider for the octave at OCT_RESET; zero marks an unmapped key.
  function automatic logic [7:0] base_of(input logic [3:0] key);
    logic [7:0] b;
    case (key)
      4'h1:    b = 8'd215;
      4'h2:    b = 8'd204;
      4'h3:    b = 8'd191;
      4'hA:    b = 8'd181;
      4'h4:    b = 8'd171;
      4'h5:    b = 8'd161;
      4'h6:    b = 8'd152;
      4'hB:    b = 8'd145;
      4'h7:    b = 8'd136;
      4'h8:    b = 8'd128;
      4'h9:    b = 8'd121;
      4'hC:    b = 8'd114;
      default: b = 8'd0;
    endcase
    return b;
  endfunction

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] tgt_q, tgt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OCT_W-1:0] oct_q, oct_d;
  logic             up_prev_q, up_prev_d;
  logic             dn_prev_q, dn_prev_d;
  logic             note_active_q, note_active_d;
  logic             gliding_q, gliding_d;

  logic             up_rise_s, dn_rise_s;
  logic [7:0]       base_s;
  logic             mapped_s;
  logic [DIV_W-1:0] shifted_s, tgt_calc_s, tgt_eff_s, div_step_s;

  // Octave edge detection and saturating octave register update.
  always_comb begin
    up_prev_d = oct_up_i;
    dn_prev_d = oct_dn_i;
    up_rise_s = oct_up_i & ~up_prev_q;
    dn_rise_s = oct_dn_i & ~dn_prev_q;
    oct_d     = oct_q;
    if (up_rise_s && !dn_rise_s) begin
      if (oct_q != OCT_TOP) oct_d = oct_q + OCT_W'(1);
      else                  oct_d = oct_q;
    end else if (dn_rise_s && !up_rise_s) begin
      if (oct_q != '0) oct_d = oct_q - OCT_W'(1);
      else             oct_d = oct_q;
    end else begin
      oct_d = oct_q;
    end
  end

  // Target uses the registered octave, so an octave change retargets one edge later.
  always_comb begin
    base_s   = base_of(key_value_i);
    mapped_s = key_valid_i & (base_s != 8'd0);
    if (oct_q <= OCT_HOME) shifted_s = DIV_W'(base_s) << (OCT_HOME - oct_q);
    else                   shifted_s = DIV_W'(base_s) >> (oct_q - OCT_HOME);
    if (shifted_s == '0) tgt_calc_s = DIV_ONE;
    else                 tgt_calc_s = shifted_s;
    if (mapped_s) tgt_eff_s = tgt_calc_s;
    else          tgt_eff_s = tgt_q;
    if (tgt_eff_s < div_q) div_step_s = div_q - DIV_ONE;
    else                   div_step_s = div_q + DIV_ONE;
  end

  // Note FSM: next state, divider value, glide step counter and output flags.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_eff_s;
    case (state_q)
      ST_IDLE: begin
        if (mapped_s) begin
          if (glide_en_i && (tgt_calc_s != div_q)) begin
            state_d = ST_GLIDE;
            cnt_d   = '0;
          end else begin
            div_d   = tgt_calc_s;
            state_d = ST_HOLD;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HOLD: begin
        if (!key_valid_i) begin
          state_d = ST_IDLE;
        end else if (mapped_s && (tgt_calc_s != div_q)) begin
          if (glide_en_i) begin
            state_d = ST_GLIDE;
            cnt_d   = '0;
          end else begin
            div_d   = tgt_calc_s;
          end
        end else begin
          state_d = ST_HOLD;
        end
      end
      ST_GLIDE: begin
        if (!key_valid_i) begin
          state_d = ST_IDLE;
        end else if (!glide_en_i) begin
          div_d   = tgt_eff_s;
          state_d = ST_HOLD;
        end else if (div_q == tgt_eff_s) begin
          state_d = ST_HOLD;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          div_d = div_step_s;
          if (div_step_s == tgt_eff_s) state_d = ST_HOLD;
          else                         state_d = ST_GLIDE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    note_active_d = (state_d != ST_IDLE);
    gliding_d     = (state_d == ST_GLIDE);
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= ST_IDLE;
      div_q         <= DIV_RESET;
      tgt_q         <= DIV_RESET;
      cnt_q         <= '0;
      oct_q         <= OCT_HOME;
      up_prev_q     <= 1'b0;
      dn_prev_q     <= 1'b0;
      note_active_q <= 1'b0;
      gliding_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      tgt_q         <= tgt_d;
      cnt_q         <= cnt_d;
      oct_q         <= oct_d;
      up_prev_q     <= up_prev_d;
      dn_prev_q     <= dn_prev_d;
      note_active_q <= note_active_d;
      gliding_q     <= gliding_d;
    end
  end

  assign div_factor_o  = div_q;
  assign note_active_o = note_active_q;
  assign gliding_o     = gliding_q;
  assign oct_o         = oct_q;

endmodule

// File: tb/tb_note_divider_ctrl.sv
// Bench for note_divider_ctrl: directed test-plan steps followed by random
// keypad activity, all checked against a behavioural note model.
module tb_note_divider_ctrl;

  localparam int DIV_W     = 16;
  localparam int OCT_MAX   = 4;
  localparam int OCT_RESET = 2;
  localparam int GLIDE_DIV = 4;
  localparam int OCT_W     = $clog2(OCT_MAX + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             kv;
  logic [3:0]       kval;
  logic             up, dn, ge;
  logic [DIV_W-1:0] div;
  logic             act, gl;
  logic [OCT_W-1:0] oct;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  note_divider_ctrl #(
    .DIV_W(DIV_W), .OCT_MAX(OCT_MAX), .OCT_RESET(OCT_RESET), .GLIDE_DIV(GLIDE_DIV), .OCT_W(OCT_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .key_valid_i(kv), .key_value_i(kval),
    .oct_up_i(up), .oct_dn_i(dn), .glide_en_i(ge),
    .div_factor_o(div), .note_active_o(act), .gliding_o(gl), .oct_o(oct)
  );

  // Behavioural model: note frequencies as plain arithmetic, glide as elapsed-time steps.
  int base_tbl[16] = '{0, 215, 204, 191, 171, 161, 152, 136, 128, 121, 181, 145, 114, 0, 0, 0};
  int m_div, m_oct, m_tgt, m_age;
  bit m_active, m_gliding, m_up_prev, m_dn_prev;

  function automatic int note_target(int key, int octv);
    int t;
    if (octv <= OCT_RESET) t = base_tbl[key] * (1 << (OCT_RESET - octv));
    else                   t = base_tbl[key] / (1 << (octv - OCT_RESET));
    if (t == 0) t = 1;
    return t;
  endfunction

  task automatic model_reset();
    m_div = 128; m_oct = OCT_RESET; m_tgt = 128; m_age = 0;
    m_active = 1'b0; m_gliding = 1'b0; m_up_prev = 1'b0; m_dn_prev = 1'b0;
  endtask

  task automatic start_note(int t);
    m_active = 1'b1;
    if (ge && t != m_div) begin
      m_gliding = 1'b1;
      m_age = 0;
    end else begin
      m_gliding = 1'b0;
      m_div = t;
    end
  endtask

  task automatic model_step();
    bit ur, dr, mapped;
    int t, old_oct;
    ur = up && !m_up_prev;
    dr = dn && !m_dn_prev;
    m_up_prev = up;
    m_dn_prev = dn;
    old_oct = m_oct;
    if (ur && !dr && m_oct < OCT_MAX) m_oct = m_oct + 1;
    if (dr && !ur && m_oct > 0)       m_oct = m_oct - 1;
    mapped = kv && (base_tbl[kval] != 0);
    if (mapped) m_tgt = note_target(int'(kval), old_oct);
    t = m_tgt;
    if (!m_active) begin
      if (mapped) start_note(t);
    end else if (!kv) begin
      m_active = 1'b0;
      m_gliding = 1'b0;
    end else if (!m_gliding) begin
      if (mapped && t != m_div) start_note(t);
    end else if (!ge) begin
      m_div = t;
      m_gliding = 1'b0;
    end else if (m_div == t) begin
      m_gliding = 1'b0;
    end else begin
      m_age = m_age + 1;
      if (m_age % GLIDE_DIV == 0) begin
        m_div = (t < m_div) ? m_div - 1 : m_div + 1;
        if (m_div == t) m_gliding = 1'b0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    chk("div_model", 32'(div), 32'(m_div));
    chk("active_model", 32'(act), 32'(m_active));
    chk("gliding_model", 32'(gl), 32'(m_gliding));
    chk("oct_model", 32'(oct), 32'(m_oct));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Raise reset between edges and check outputs change without waiting for a clock.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    #1;
    chk({tag, "_div"}, 32'(div), 32'd128);
    chk({tag, "_act"}, 32'(act), 32'd0);
    chk({tag, "_gl"}, 32'(gl), 32'd0);
    chk({tag, "_oct"}, 32'(oct), 32'd2);
    model_reset();
    kv = 1'b0; up = 1'b0; dn = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulse_up();
    up = 1'b1; tick();
    up = 1'b0; tick();
  endtask

  task automatic pulse_dn();
    dn = 1'b1; tick();
    dn = 1'b0; tick();
  endtask

  initial begin
    rst = 1'b0; kv = 1'b0; kval = 4'h0; up = 1'b0; dn = 1'b0; ge = 1'b0;
    async_reset("reset");

    // Jump to key 1 and release.
    kv = 1'b1; kval = 4'h1; tick();
    chk("jump_div", 32'(div), 32'd215);
    chk("jump_act", 32'(act), 32'd1);
    kv = 1'b0; tick();
    chk("release_act", 32'(act), 32'd0);
    chk("release_div", 32'(div), 32'd215);

    // Octave shifting with key 8 held.
    kv = 1'b1; kval = 4'h8; tick();
    chk("key8_div", 32'(div), 32'd128);
    up = 1'b1; tick();
    chk("oct_up_oct", 32'(oct), 32'd3);
    up = 1'b0; tick();
    chk("oct_up_div", 32'(div), 32'd64);
    pulse_up(); pulse_up();
    chk("oct_sat_oct", 32'(oct), 32'd4);
    chk("oct_sat_div", 32'(div), 32'd32);
    for (int i = 0; i < 6; i++) pulse_dn();
    chk("oct_min_oct", 32'(oct), 32'd0);
    chk("oct_min_div", 32'(div), 32'd512);
    up = 1'b1; dn = 1'b1; tick();
    up = 1'b0; dn = 1'b0; tick();
    chk("oct_both_oct", 32'(oct), 32'd0);
    chk("oct_both_div", 32'(div), 32'd512);
    pulse_up(); pulse_up();
    chk("oct_home_div", 32'(div), 32'd128);

    // Full glide 128 -> 114.
    ge = 1'b1; kval = 4'hC; tick();
    chk("glide_start_gl", 32'(gl), 32'd1);
    chk("glide_start_div", 32'(div), 32'd128);
    ticks(55);
    chk("glide_55_div", 32'(div), 32'd115);
    chk("glide_55_gl", 32'(gl), 32'd1);
    tick();
    chk("glide_end_div", 32'(div), 32'd114);
    chk("glide_end_gl", 32'(gl), 32'd0);

    // Glide interrupted by release.
    ge = 1'b0; kval = 4'h8; tick();
    ge = 1'b1; kval = 4'hC; tick();
    ticks(20);
    kv = 1'b0; tick();
    chk("glide_rel_div", 32'(div), 32'd123);
    chk("glide_rel_act", 32'(act), 32'd0);
    ticks(5);
    chk("glide_frozen_div", 32'(div), 32'd123);

    // Octave change and glide disable mid-glide.
    ge = 1'b0; kv = 1'b1; kval = 4'h8; tick();
    ge = 1'b1; kval = 4'hC; tick();
    ticks(5);
    up = 1'b1; tick();
    up = 1'b0; tick();
    tick();
    chk("mid_oct_div", 32'(div), 32'd126);
    chk("mid_oct_gl", 32'(gl), 32'd1);
    ticks(3);
    ge = 1'b0; tick();
    chk("glide_off_div", 32'(div), 32'd57);
    chk("glide_off_gl", 32'(gl), 32'd0);
    pulse_dn();
    chk("back_home_div", 32'(div), 32'd114);

    // Unmapped keys are ignored.
    kval = 4'h8; tick();
    kval = 4'hD; tick();
    chk("ignore_d_div", 32'(div), 32'd128);
    chk("ignore_d_act", 32'(act), 32'd1);
    kv = 1'b0; tick();
    kv = 1'b1; kval = 4'h0; tick();
    chk("ignore_0_act", 32'(act), 32'd0);
    kv = 1'b0; tick();

    // Reset in the middle of a glide.
    ge = 1'b1; kv = 1'b1; kval = 4'h1; tick();
    ticks(9);
    async_reset("reset_glide");

    // Random keypad activity.
    ge = 1'b0; kv = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 15) == 0) kv = ~kv;
      if ($urandom_range(0, 7) == 0)  kval = 4'($urandom_range(0, 15));
      up = ($urandom_range(0, 24) == 0);
      dn = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 39) == 0) ge = ~ge;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
